// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: reset PC, primary opcode values and the
// fetch-unit state encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    localparam logic [5:0] R_TYPE      = 6'h00;
    localparam logic [5:0] I_TYPE_ADDI = 6'h08;
    localparam logic [5:0] I_TYPE_ORI  = 6'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter storage: asynchronously reset register with load enable.
module pc_register #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (load_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads one word per instruction over a
// req/ack handshake and holds it for decode until it is consumed.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    output logic             instr_valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [5:0]       opcode_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             misalign_o,
    output logic [31:0]      instr_count_o
);

    fetch_state_t     state_r, state_nxt;
    logic             capture, consume;
    logic [WIDTH-1:0] pc_r, pc_nxt, instr_r;
    logic [31:0]      count_r;
    logic             misalign_r;

    function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
        return {addr[WIDTH-1:2], 2'b00};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: if (imem_ack_i) state_nxt = ST_VALID;
            ST_VALID: if (!stall_i) state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign capture = (state_r == ST_FETCH) && imem_ack_i;
    assign consume = (state_r == ST_VALID) && !stall_i;
    assign pc_nxt  = branch_taken_i ? word_align(branch_target_i) : pc_r + WIDTH'(4);

    pc_register #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .load_en (consume),
        .d       (pc_nxt),
        .q       (pc_r)
    );

    // Reset value of the latch decodes as R-type; consumers gate on instr_valid_o.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r    <= {R_TYPE, {(WIDTH-6){1'b0}}};
            count_r    <= '0;
            misalign_r <= 1'b0;
        end else begin
            if (capture) begin
                instr_r <= imem_rdata_i;
            end
            if (consume) begin
                count_r <= count_r + 32'd1;
                if (branch_taken_i && (branch_target_i[1:0] != 2'b00)) begin
                    misalign_r <= 1'b1;
                end
            end
        end
    end

    assign imem_req_o    = (state_r == ST_FETCH);
    assign imem_addr_o   = pc_r;
    assign instr_valid_o = (state_r == ST_VALID);
    assign instr_o       = instr_r;
    assign opcode_o      = instr_r[WIDTH-1 -: 6];
    assign pc_o          = pc_r;
    assign pc_plus4_o    = pc_r + WIDTH'(4);
    assign misalign_o    = misalign_r;
    assign instr_count_o = count_r;

endmodule
